avalon_mm_regfile_slave: RTL and testbench



---
 rtl/avalon_pkg.sv | 13 +
 rtl/avalon_regfile_mem.sv | 34 +++
 rtl/avalon_mm_regfile_slave.sv | 153 +++++++++++++++
 tb/tb_avalon_mm_regfile_slave.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/avalon_pkg.sv
// Shared definitions for the Avalon-MM register-file slave: response codes and FSM states.
package avalon_pkg;

    localparam logic [1:0] RESP_OKAY        = 2'b00;
    localparam logic [1:0] RESP_DECODEERROR = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

endpackage

// File: rtl/avalon_regfile_mem.sv
// DEPTH x DW register storage: byte-lane write enables, combinational read port.
module avalon_regfile_mem #(
    parameter int DW    = 32,
    parameter int DEPTH = 64,
    parameter int MAW   = 6
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            we,
    input  logic [DW/8-1:0] be,
    input  logic [MAW-1:0]  addr,
    input  logic [DW-1:0]   wdata,
    output logic [DW-1:0]   rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            for (int b = 0; b < DW/8; b++) begin
                if (be[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/avalon_mm_regfile_slave.sv
// Avalon-MM register-bank slave: waitrequest flow control, programmable wait states,
// read-only ID word at address 0 and DECODEERROR for out-of-range or read+write requests.
module avalon_mm_regfile_slave
    import avalon_pkg::*;
#(
    parameter int             AW          = 8,
    parameter int             DW          = 32,
    parameter int             DEPTH       = 64,
    parameter int             WAIT_CYCLES = 1,
    parameter logic [DW-1:0]  ID_VALUE    = DW'(32'hA7A1_0001)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [AW-1:0]   address,
    input  logic            read,
    input  logic            write,
    input  logic [DW-1:0]   writedata,
    input  logic [DW/8-1:0] byteenable,
    output logic            waitrequest,
    output logic [DW-1:0]   readdata,
    output logic [1:0]      response
);

    localparam int            BW      = DW / 8;
    localparam int            MAW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]    WC      = 4'(WAIT_CYCLES);
    localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);

    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
        $error("WAIT_CYCLES must be in 0..15");
    end
    if (DW % 8 != 0) begin : g_bad_dw
        $error("DW must be a multiple of 8");
    end
    if (DEPTH < 1 || DEPTH > (1 << AW)) begin : g_bad_depth
        $error("DEPTH must be in 1..2**AW");
    end

    state_t          state;
    logic [3:0]      wait_cnt;
    logic [AW-1:0]   cmd_addr;
    logic            cmd_read;
    logic            cmd_write;
    logic [DW-1:0]   cmd_wdata;
    logic [BW-1:0]   cmd_be;

    logic [AW-1:0]   eff_addr;
    logic            eff_read;
    logic            eff_write;
    logic [DW-1:0]   eff_wdata;
    logic [BW-1:0]   eff_be;
    logic            ack_entry;
    logic            in_range;
    logic            legal;
    logic            mem_we;
    logic [DW-1:0]   mem_rdata;
    logic [1:0]      resp_next;
    logic [DW-1:0]   rdata_next;

    // With zero wait states ACK is entered on the capture edge, so the live bus is the command.
    always_comb begin
        eff_addr  = cmd_addr;
        eff_read  = cmd_read;
        eff_write = cmd_write;
        eff_wdata = cmd_wdata;
        eff_be    = cmd_be;
        if (state == IDLE) begin
            eff_addr  = address;
            eff_read  = read;
            eff_write = write;
            eff_wdata = writedata;
            eff_be    = byteenable;
        end
    end

    always_comb begin
        ack_entry  = ((state == IDLE) && (read || write) && (WC == 4'd0)) ||
                     ((state == WAIT) && (wait_cnt == 4'd1));
        in_range   = {1'b0, eff_addr} < DEPTH_W;
        legal      = eff_read ^ eff_write;
        mem_we     = ack_entry && eff_write && !eff_read && in_range && (eff_addr != '0);
        resp_next  = (in_range && legal) ? RESP_OKAY : RESP_DECODEERROR;
        rdata_next = '0;
        if (in_range && legal) begin
            rdata_next = (eff_addr == '0) ? ID_VALUE : mem_rdata;
        end
    end

    avalon_regfile_mem #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .MAW   (MAW)
    ) u_mem (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (mem_we),
        .be      (eff_be),
        .addr    (eff_addr[MAW-1:0]),
        .wdata   (eff_wdata),
        .rdata   (mem_rdata)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            cmd_addr    <= '0;
            cmd_read    <= 1'b0;
            cmd_write   <= 1'b0;
            cmd_wdata   <= '0;
            cmd_be      <= '0;
            waitrequest <= 1'b1;
            readdata    <= '0;
            response    <= RESP_OKAY;
        end else begin
            waitrequest <= !ack_entry;
            response    <= ack_entry ? resp_next : RESP_OKAY;
            if (ack_entry && eff_read) begin
                readdata <= rdata_next;
            end
            case (state)
                IDLE: begin
                    if (read || write) begin
                        cmd_addr  <= address;
                        cmd_read  <= read;
                        cmd_write <= write;
                        cmd_wdata <= writedata;
                        cmd_be    <= byteenable;
                        if (WC == 4'd0) begin
                            state <= ACK;
                        end else begin
                            wait_cnt <= WC;
                            state    <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt == 4'd1) begin
                        state <= ACK;
                    end
                end
                ACK: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_avalon_mm_regfile_slave.sv
// Bench for avalon_mm_regfile_slave: three instances (1, 0 and 3 wait states) against a register-array model.
module tb_avalon_mm_regfile_slave;

    localparam int          DEPTH = 64;
    localparam logic [31:0] ID    = 32'hA7A1_0001;
    localparam int          NDUT  = 3;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  address     [NDUT];
    logic        read        [NDUT];
    logic        write       [NDUT];
    logic [31:0] writedata   [NDUT];
    logic [3:0]  byteenable  [NDUT];
    logic        waitrequest [NDUT];
    logic [31:0] readdata    [NDUT];
    logic [1:0]  response    [NDUT];

    int          exp_wc  [NDUT] = '{1, 0, 3};
    logic [31:0] model   [NDUT][DEPTH];
    logic [31:0] last_rd [NDUT];
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        avalon_mm_regfile_slave #(
            .WAIT_CYCLES((g == 0) ? 1 : (g == 1) ? 0 : 3)
        ) u_dut (
            .clk         (clk),
            .reset_n     (reset_n),
            .address     (address[g]),
            .read        (read[g]),
            .write       (write[g]),
            .writedata   (writedata[g]),
            .byteenable  (byteenable[g]),
            .waitrequest (waitrequest[g]),
            .readdata    (readdata[g]),
            .response    (response[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_model();
        for (int d = 0; d < NDUT; d++) begin
            last_rd[d] = '0;
            for (int i = 0; i < DEPTH; i++) model[d][i] = '0;
        end
    endtask

    // One complete transfer on instance d, with expectations taken from the register-bank rules.
    task automatic xfer(input int d, input bit rd, input bit wr, input int a,
                        input logic [31:0] wd, input logic [3:0] be);
        logic [31:0] exp_rd;
        logic [1:0]  exp_resp;
        int          lat;
        exp_rd = last_rd[d];
        if ((rd && wr) || a >= DEPTH) begin
            exp_resp = 2'b11;
            if (rd) exp_rd = '0;
        end else begin
            exp_resp = 2'b00;
            if (wr) begin
                if (a != 0)
                    for (int b = 0; b < 4; b++)
                        if (be[b]) model[d][a][8*b +: 8] = wd[8*b +: 8];
            end else begin
                exp_rd = (a == 0) ? ID : model[d][a];
            end
        end
        last_rd[d] = exp_rd;

        @(negedge clk);
        address[d]    = 8'(a);
        read[d]       = rd;
        write[d]      = wr;
        writedata[d]  = wd;
        byteenable[d] = be;
        @(posedge clk);
        #1;
        lat = 0;
        while (waitrequest[d] && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        read[d]  = 1'b0;
        write[d] = 1'b0;
        chk($sformatf("latency_dut%0d", d), 32'(lat), 32'(exp_wc[d]));
        chk($sformatf("response_dut%0d_a%0d", d, a), 32'(response[d]), 32'(exp_resp));
        chk($sformatf("readdata_dut%0d_a%0d", d, a), readdata[d], exp_rd);
        @(posedge clk);
        #1;
        chk($sformatf("wr_high_after_ack_dut%0d", d), 32'(waitrequest[d]), 32'd1);
        chk($sformatf("resp_idle_dut%0d", d), 32'(response[d]), 32'd0);
    endtask

    initial begin
        for (int d = 0; d < NDUT; d++) begin
            address[d] = '0; read[d] = 1'b0; write[d] = 1'b0;
            writedata[d] = '0; byteenable[d] = '0;
        end
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < NDUT; d++) begin
            chk($sformatf("reset_wr_dut%0d", d), 32'(waitrequest[d]), 32'd1);
            chk($sformatf("reset_rd_dut%0d", d), readdata[d], 32'd0);
            chk($sformatf("reset_resp_dut%0d", d), 32'(response[d]), 32'd0);
        end
        @(negedge clk);
        reset_n = 1'b1;

        for (int d = 0; d < NDUT; d++) begin
            xfer(d, 1, 0, 5, 0, 4'h0);
            xfer(d, 0, 1, 10, 32'd20, 4'hF);
            xfer(d, 1, 0, 10, 0, 4'h0);
            xfer(d, 0, 1, 15, 32'h1122_3344, 4'hF);
            xfer(d, 0, 1, 15, 32'hAABB_CCDD, 4'b0101);
            xfer(d, 1, 0, 15, 0, 4'h0);
            chk($sformatf("merge_dut%0d", d), readdata[d], 32'h11BB_33DD);
            xfer(d, 1, 0, 0, 0, 4'h0);
            xfer(d, 0, 1, 0, 32'd25, 4'hF);
            xfer(d, 1, 0, 0, 0, 4'h0);
            xfer(d, 1, 0, 200, 0, 4'h0);
            xfer(d, 0, 1, 200, 32'hDEAD_BEEF, 4'hF);
            xfer(d, 1, 1, 12, 32'h5555_5555, 4'hF);
            xfer(d, 1, 0, 12, 0, 4'h0);
            xfer(d, 0, 1, 63, 32'hCAFE_F00D, 4'h0);
            xfer(d, 1, 0, 63, 0, 4'h0);
        end

        // Reset in the middle of a 3-wait-state write: the write must not land.
        @(negedge clk);
        address[2] = 8'd8; write[2] = 1'b1; writedata[2] = 32'd99; byteenable[2] = 4'hF;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        write[2] = 1'b0;
        #1;
        chk("async_reset_wr", 32'(waitrequest[2]), 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        clear_model();
        xfer(2, 1, 0, 8, 0, 4'h0);

        for (int n = 0; n < 300; n++) begin
            int d, op, a;
            d  = $urandom_range(0, NDUT - 1);
            op = $urandom_range(0, 9);
            a  = ($urandom_range(0, 3) == 0) ? $urandom_range(64, 255) : $urandom_range(0, 15);
            xfer(d, (op <= 3) || (op == 9), op >= 4, a, $urandom, 4'($urandom_range(0, 15)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
